// File: rtl/calc_pkg.sv
// Shared definitions for the tile dispatcher and the placement calculator:
// tile codes, FSM states and the tile footprint lookup.
package calc_pkg;

    localparam logic [3:0] TILE_I        = 4'd0;
    localparam logic [3:0] TILE_O        = 4'd1;
    localparam int unsigned NO_PROPER_POS = 11;
    localparam int unsigned HEIGHT_W      = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_PLACE,
        S_OVER
    } state_t;

    typedef struct packed {
        logic [2:0] width;
        logic [2:0] height;
    } footprint_t;

    // Odd rotations stand the I-bar upright; the square is rotation-invariant.
    function automatic footprint_t footprint(input logic [3:0] tile, input logic [1:0] rot);
        footprint_t fp;
        if (tile == TILE_I) begin
            fp.width  = rot[0] ? 3'd1 : 3'd4;
            fp.height = rot[0] ? 3'd4 : 3'd1;
        end else begin
            fp.width  = 3'd2;
            fp.height = 3'd2;
        end
        return fp;
    endfunction

endpackage

// File: rtl/tile_lfsr.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1) that picks the next tile.
// Only bit 0 is exposed since it alone selects the tile code.
module tile_lfsr #(
    parameter logic [3:0] SEED = 4'b1001
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_adv,
    output logic o_bit
);

    logic [3:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= SEED;
        end else if (i_adv) begin
            r_q <= {r_q[2:0], r_q[3] ^ r_q[2]};
        end
    end

    assign o_bit = r_q[0];

endmodule

// File: rtl/tile_dispatcher.sv
// Game-side driver: requests a placement per tile, validates the answer and
// commits it to the column height map, tracking errors and game-over.
module tile_dispatcher
    import calc_pkg::*;
#(
    parameter int unsigned COLS    = 10,
    parameter int unsigned MAX_H   = 16,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [3:0]  SEED    = 4'b1001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                req_to_client,
    output logic [3:0]          cur_block,
    input  logic                resp_from_client,
    input  logic [3:0]          opt_col,
    input  logic [1:0]          opt_rotation,
    output logic                busy,
    output logic                game_over,
    output logic [15:0]         tiles_placed,
    output logic [7:0]          err_count,
    output logic [HEIGHT_W-1:0] max_height
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    state_t              r_state, w_next;
    logic                w_lfsr_adv, w_lfsr_bit;
    logic [3:0]          r_cur_block;
    logic [3:0]          r_col;
    logic [1:0]          r_rot;
    logic                r_err;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [HEIGHT_W-1:0] r_heights [COLS];
    logic                r_game_over;
    logic [15:0]         r_tiles;
    logic [7:0]          r_err_cnt;
    logic [HEIGHT_W-1:0] r_max_h;

    footprint_t          w_fp;
    logic [4:0]          w_lo, w_hi;
    logic [COLS-1:0]     w_cover;
    logic                w_illegal, w_timeout, w_overflow;
    logic [HEIGHT_W-1:0] w_base;
    logic [5:0]          w_top;

    tile_lfsr #(.SEED(SEED)) u_lfsr (
        .i_clk (clk),
        .i_rst (rst),
        .i_adv (w_lfsr_adv),
        .o_bit (w_lfsr_bit)
    );

    // Footprint bounds serve CHECK (legality) and PLACE (covered columns).
    always_comb begin
        w_fp      = footprint(r_cur_block, r_rot);
        w_lo      = {1'b0, r_col};
        w_hi      = w_lo + {2'b00, w_fp.width};
        w_illegal = w_hi > 5'(COLS);
        w_cover   = '0;
        w_base    = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            w_cover[IDX_W'(c)] = (5'(c) >= w_lo) && (5'(c) < w_hi);
            if (w_cover[IDX_W'(c)] && (r_heights[IDX_W'(c)] > w_base)) begin
                w_base = r_heights[IDX_W'(c)];
            end
        end
        w_top      = {1'b0, w_base} + {3'b000, w_fp.height};
        w_overflow = w_top > 6'(MAX_H);
        w_timeout  = r_wait_cnt == CNT_W'(TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_lfsr_adv    = 1'b0;
        req_to_client = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                req_to_client = 1'b1;
                w_lfsr_adv    = 1'b1;
                w_next        = S_WAIT;
            end
            S_WAIT: begin
                if (resp_from_client || w_timeout) w_next = S_CHECK;
            end
            S_CHECK: w_next = S_PLACE;
            S_PLACE: begin
                if (w_overflow)  w_next = S_OVER;
                else if (run)    w_next = S_ISSUE;
                else             w_next = S_IDLE;
            end
            S_OVER: busy = 1'b0;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_block <= '0;
            r_col       <= '0;
            r_rot       <= '0;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
            r_game_over <= 1'b0;
            r_tiles     <= '0;
            r_err_cnt   <= '0;
            r_max_h     <= '0;
            for (int unsigned c = 0; c < COLS; c++) r_heights[IDX_W'(c)] <= '0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    r_cur_block <= w_lfsr_bit ? TILE_O : TILE_I;
                    r_wait_cnt  <= CNT_W'(1);
                    r_err       <= 1'b0;
                end
                S_WAIT: begin
                    // A response in the timeout cycle takes priority over the fallback.
                    if (resp_from_client) begin
                        r_col <= opt_col;
                        r_rot <= opt_rotation;
                    end else if (w_timeout) begin
                        r_col <= '0;
                        r_rot <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        r_col <= '0;
                        r_rot <= '0;
                    end
                    if ((r_err || w_illegal) && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                S_PLACE: begin
                    if (w_overflow) begin
                        r_game_over <= 1'b1;
                    end else begin
                        for (int unsigned c = 0; c < COLS; c++) begin
                            if (w_cover[IDX_W'(c)]) r_heights[IDX_W'(c)] <= w_top[HEIGHT_W-1:0];
                        end
                        r_tiles <= r_tiles + 16'd1;
                        if (w_top[HEIGHT_W-1:0] > r_max_h) r_max_h <= w_top[HEIGHT_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign cur_block    = (r_state == S_ISSUE) ? (w_lfsr_bit ? TILE_O : TILE_I) : r_cur_block;
    assign game_over    = r_game_over;
    assign tiles_placed = r_tiles;
    assign err_count    = r_err_cnt;
    assign max_height   = r_max_h;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Scoreboard bench for tile_dispatcher: a behavioural game model predicts each
// request and commit; a monitor compares them as the DUT presents them.
module tb_tile_dispatcher;

    localparam int COLS    = 10;
    localparam int MAX_H   = 16;
    localparam int TIMEOUT = 16;
    localparam logic [3:0] SEED = 4'b1001;
    localparam int HMAP_W  = COLS * 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        req_to_client;
    logic [3:0]  cur_block;
    logic        resp = 1'b0;
    logic [3:0]  opt_col = '0;
    logic [1:0]  opt_rotation = '0;
    logic        busy, game_over;
    logic [15:0] tiles_placed;
    logic [7:0]  err_count;
    logic [4:0]  max_height;

    tile_dispatcher #(
        .COLS    (COLS),
        .MAX_H   (MAX_H),
        .TIMEOUT (TIMEOUT),
        .SEED    (SEED)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .run              (run),
        .req_to_client    (req_to_client),
        .cur_block        (cur_block),
        .resp_from_client (resp),
        .opt_col          (opt_col),
        .opt_rotation     (opt_rotation),
        .busy             (busy),
        .game_over        (game_over),
        .tiles_placed     (tiles_placed),
        .err_count        (err_count),
        .max_height       (max_height)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic [3:0] tile;
        logic       cv;
        int         cyc;
    } req_exp_t;

    typedef struct packed {
        logic [15:0]       tiles;
        logic [7:0]        err;
        logic [4:0]        maxh;
        logic              over;
        int                cyc;
        logic [HMAP_W-1:0] hmap;
    } commit_t;

    req_exp_t q_req[$];
    commit_t  q_exp[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Game model state
    int m_lfsr, m_tiles, m_err, m_maxh;
    bit m_over;
    int m_h[COLS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [HMAP_W-1:0] model_hmap();
        logic [HMAP_W-1:0] v;
        v = '0;
        for (int i = 0; i < COLS; i++) v[i*5 +: 5] = 5'(m_h[i]);
        return v;
    endfunction

    function automatic logic [HMAP_W-1:0] dut_hmap();
        logic [HMAP_W-1:0] v;
        v = '0;
        for (int i = 0; i < COLS; i++) v[i*5 +: 5] = dut.r_heights[i];
        return v;
    endfunction

    task automatic model_init();
        req_exp_t re;
        m_lfsr = int'(SEED);
        m_tiles = 0; m_err = 0; m_maxh = 0; m_over = 0;
        for (int i = 0; i < COLS; i++) m_h[i] = 0;
        q_req.delete();
        q_exp.delete();
        re.tile = 4'(m_lfsr & 1); re.cv = 1'b0; re.cyc = 0;
        q_req.push_back(re);
    endtask

    task automatic shape(input int tile, input int r, output int w, output int h);
        if (tile == 1) begin w = 2; h = 2; end
        else if (r % 2 == 1) begin w = 1; h = 4; end
        else begin w = 4; h = 1; end
    endtask

    // Predicts one tile: d = response delay in cycles after the request (0 = never).
    task automatic model_tile(input int t, input int d, input int col, input int rot, input bit last);
        int tile, c, r, w, h, base, top, dd, fb;
        bit err;
        commit_t ce;
        req_exp_t re;
        tile = m_lfsr & 1;
        fb = ((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 15;
        if (d >= 1 && d <= TIMEOUT) begin c = col; r = rot; err = 0; dd = d; end
        else begin c = 0; r = 0; err = 1; dd = TIMEOUT; end
        shape(tile, r, w, h);
        if (c + w > COLS) begin c = 0; r = 0; err = 1; shape(tile, r, w, h); end
        if (err && m_err < 255) m_err++;
        base = 0;
        for (int i = c; i < c + w; i++) if (m_h[i] > base) base = m_h[i];
        top = base + h;
        if (top > MAX_H) m_over = 1;
        else begin
            for (int i = c; i < c + w; i++) m_h[i] = top;
            m_tiles = (m_tiles + 1) % 65536;
            if (top > m_maxh) m_maxh = top;
        end
        ce.tiles = 16'(m_tiles); ce.err = 8'(m_err); ce.maxh = 5'(m_maxh);
        ce.over = m_over; ce.cyc = t + dd + 3; ce.hmap = model_hmap();
        q_exp.push_back(ce);
        if (!m_over) begin
            re.tile = 4'(m_lfsr & 1); re.cv = !last; re.cyc = t + dd + 3;
            q_req.push_back(re);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; run = 1'b0; resp = 1'b0;
        model_init();
        repeat (n) @(negedge clk);
        check("rst req", req_to_client, 0);
        check("rst cur_block", cur_block, 0);
        check("rst busy", busy, 0);
        check("rst game_over", game_over, 0);
        check("rst tiles", tiles_placed, 0);
        check("rst err", err_count, 0);
        check("rst max_height", max_height, 0);
        check("rst heights", dut_hmap(), 0);
        rst = 1'b0;
    endtask

    // Waits for a request, predicts its outcome, then answers after d cycles.
    task automatic do_tile(input int d, input int col, input int rot, input bit last, input bit noise);
        int budget, t;
        budget = 0;
        while (!req_to_client && budget < 200) begin @(negedge clk); budget++; end
        if (!req_to_client) begin check("req_seen", 0, 1); return; end
        t = cyc;
        if (last) run = 1'b0;
        model_tile(t, d, col, rot, last);
        if (noise) begin resp = 1'b1; opt_col = 4'd7; opt_rotation = 2'd1; end
        for (int k = 1; k <= ((d == 0) ? 1 : d); k++) begin
            @(negedge clk);
            resp = (d != 0) && (k == d);
            if (resp) begin opt_col = 4'(col); opt_rotation = 2'(rot); end
        end
        if (d != 0) begin @(negedge clk); resp = 1'b0; end
    endtask

    // Monitor: checks every request and every commit against the model queues.
    logic [15:0] prev_tiles = '0;
    logic        prev_go = 1'b0;
    always @(negedge clk) begin
        req_exp_t re;
        commit_t  ce;
        if (rst) begin
            prev_tiles = '0; prev_go = 1'b0;
        end else begin
            if (req_to_client) begin
                if (q_req.size() == 0) check("unexpected_req", 1, 0);
                else begin
                    re = q_req.pop_front();
                    check("cur_block", cur_block, re.tile);
                    if (re.cv) check("req_cycle", cyc, re.cyc);
                end
            end
            if (tiles_placed != prev_tiles || (game_over && !prev_go)) begin
                if (q_exp.size() == 0) check("unexpected_commit", 1, 0);
                else begin
                    ce = q_exp.pop_front();
                    check("commit_cycle", cyc, ce.cyc);
                    check("tiles_placed", tiles_placed, ce.tiles);
                    check("err_count", err_count, ce.err);
                    check("max_height", max_height, ce.maxh);
                    check("game_over", game_over, ce.over);
                    check("heights", dut_hmap(), ce.hmap);
                end
            end
            prev_tiles = tiles_placed;
            prev_go = game_over;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d, sel;
        do_reset(2);

        // Directed: square, illegal bar, timeout, response on the timeout cycle, late response
        run = 1'b1;
        do_tile(1, 3, 0, 0, 0);
        do_tile(1, 0, 2, 0, 0);
        do_tile(1, 8, 0, 0, 0);
        do_tile(0, 5, 1, 0, 0);
        do_tile(TIMEOUT, 9, 1, 0, 1);
        do_tile(TIMEOUT + 1, 2, 0, 1, 0);
        repeat (8) @(negedge clk);
        check("idle busy", busy, 0);
        check("idle drained", q_exp.size(), 0);

        // Randomized play until game over or the tile budget runs out
        run = 1'b1;
        for (int n = 0; n < 40 && !m_over; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      d = 1;
            else if (sel == 6) d = 0;
            else if (sel == 7) d = $urandom_range(2, TIMEOUT);
            else if (sel == 8) d = TIMEOUT;
            else               d = $urandom_range(TIMEOUT + 1, TIMEOUT + 2);
            do_tile(d, $urandom_range(0, 15), $urandom_range(0, 3), n == 39, $urandom_range(0, 3) == 0);
        end
        repeat (8) @(negedge clk);
        check("random drained", q_exp.size(), 0);
        check("random busy", busy, 0);
        check("random game_over", game_over, m_over);

        // Reset in the middle of WAIT; a later response must be ignored
        do_reset(2);
        run = 1'b1;
        for (int b = 0; b < 20 && !req_to_client; b++) @(negedge clk);
        check("midwait req", req_to_client, 1);
        @(negedge clk);
        @(negedge clk);
        do_reset(1);
        resp = 1'b1; opt_col = 4'd3; opt_rotation = 2'd1;
        @(negedge clk);
        resp = 1'b0;
        repeat (4) @(negedge clk);
        check("midwait busy", busy, 0);
        check("midwait tiles", tiles_placed, 0);
        check("midwait err", err_count, 0);
        check("midwait heights", dut_hmap(), 0);
        run = 1'b1;
        do_tile(1, 2, 0, 1, 0);
        repeat (6) @(negedge clk);

        // Game over: stack at column 5 upright until the column overflows
        do_reset(2);
        run = 1'b1;
        for (int n = 0; n < 24 && !m_over; n++) do_tile(1, 5, 1, 0, 0);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            resp = 1'b1; opt_col = 4'd0; opt_rotation = 2'd0;
            @(negedge clk);
            resp = 1'b0;
            @(negedge clk);
        end
        check("over game_over", game_over, 1);
        check("over busy", busy, 0);
        check("over tiles", tiles_placed, m_tiles);
        check("over heights", dut_hmap(), model_hmap());
        check("over col5 full", dut.r_heights[5] > 5'd12, 1);
        run = 1'b0;
        check("final drained", q_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
